// File: rtl/pid_pkg.sv
// Shared definitions for the PID front end and PI controller stages.
package pid_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ERR_W_DEF  = 16;

  // Working width of the generic saturate helper; every caller fits inside it.
  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    StAccum   = 2'd0,
    StCompute = 2'd1,
    StHold    = 2'd2
  } pid_state_e;

  // Clamp a sign-extended value to the range of an out_w-bit signed word.
  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] val,
                                                         input int unsigned out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/pid_error_gen_if.sv
// Measurement-in / error-out handshake bundle of the PID error generator.
interface pid_error_gen_if
  import pid_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ERR_W  = ERR_W_DEF
) ();

  logic signed [DATA_W-1:0] setpoint;
  logic                     meas_valid;
  logic signed [DATA_W-1:0] meas_data;
  logic                     meas_ready;
  logic                     err_valid;
  logic                     err_ready;
  logic signed [ERR_W-1:0]  err_data;
  logic                     sat_flag;

  modport slave (
    input  setpoint, meas_valid, meas_data, err_ready,
    output meas_ready, err_valid, err_data, sat_flag
  );

  modport master (
    output setpoint, meas_valid, meas_data, err_ready,
    input  meas_ready, err_valid, err_data, sat_flag
  );

endinterface

// File: rtl/pid_sat.sv
// Combinational deadband followed by signed saturation to OUT_W bits.
module pid_sat
  import pid_pkg::*;
#(
  parameter int unsigned IN_W     = 17,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned DEADBAND = 0
) (
  input  logic signed [IN_W-1:0]  diff,
  output logic signed [OUT_W-1:0] err,
  output logic                    sat
);

  logic signed [SAT_W-1:0] wide;
  logic signed [SAT_W-1:0] mag;
  logic signed [SAT_W-1:0] banded;
  logic signed [SAT_W-1:0] clipped;

  always_comb begin
    wide    = SAT_W'(diff);
    mag     = (wide < 0) ? -wide : wide;
    banded  = (mag <= $signed(SAT_W'(DEADBAND))) ? '0 : wide;
    clipped = sat_signed(banded, OUT_W);
    err     = clipped[OUT_W-1:0];
    sat     = (clipped != banded);
  end

endmodule

// File: rtl/pid_error_gen.sv
// Block-averages measurement samples and emits a deadbanded, saturated setpoint error.
module pid_error_gen
  import pid_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ERR_W    = ERR_W_DEF,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned DEADBAND = 0
) (
  input logic           clk,
  input logic           rst,
  pid_error_gen_if.slave bus
);

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  pid_state_e               state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     err_valid_q;
  logic signed [ERR_W-1:0]  err_data_q;
  logic                     sat_flag_q;

  logic signed [DATA_W-1:0] avg;
  logic signed [DATA_W:0]   diff;
  logic signed [ERR_W-1:0]  sat_err;
  logic                     sat_hit;

  // Dropping the low AVG_LOG2 bits is the floor (toward -inf) division.
  assign avg  = $signed(acc_q[ACC_W-1:AVG_LOG2]);
  assign diff = (DATA_W+1)'(bus.setpoint) - (DATA_W+1)'(avg);

  pid_sat #(
    .IN_W    (DATA_W + 1),
    .OUT_W   (ERR_W),
    .DEADBAND(DEADBAND)
  ) u_sat (
    .diff(diff),
    .err (sat_err),
    .sat (sat_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_valid_q <= 1'b0;
      err_data_q  <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (bus.meas_valid) begin
            acc_q <= acc_q + ACC_W'(bus.meas_data);
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_q <= StCompute;
            end
          end
        end
        StCompute: begin
          err_data_q  <= sat_err;
          sat_flag_q  <= sat_hit;
          err_valid_q <= 1'b1;
          acc_q       <= '0;
          cnt_q       <= '0;
          state_q     <= StHold;
        end
        StHold: begin
          if (bus.err_ready) begin
            err_valid_q <= 1'b0;
            state_q     <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

  // Gated with rst so no sample can be offered a transfer during reset.
  assign bus.meas_ready = (state_q == StAccum) && !rst;
  assign bus.err_valid  = err_valid_q;
  assign bus.err_data   = err_data_q;
  assign bus.sat_flag   = sat_flag_q;

endmodule
